heap_pointer: RTL

Parametrised successor to the QuickQ array counter. It holds one registered index into the array-backed heap and executes one navigation command per accepted handshake: load, clear, increment, decrement, parent, left child, right child, jump to last, push and pop of a saved-pointer stack. Every move is bounds-checked against last_index, and the block reports errors. It sits between the QuickQ control FSM and the heap storage address port.

---
 rtl/heap_pkg.sv | 27 ++
 rtl/ptr_stack.sv | 47 ++++
 rtl/heap_pointer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/heap_pkg.sv
// heap_pkg: shared types for the QuickQ heap pointer and its helpers.
//   ptr_op_e  - navigation opcodes carried on cmd_op
//   ptr_err_e - sticky error classes reported on err_code
package heap_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LOAD   = 4'd1,
    OP_CLR    = 4'd2,
    OP_INC    = 4'd3,
    OP_DEC    = 4'd4,
    OP_PARENT = 4'd5,
    OP_LCHILD = 4'd6,
    OP_RCHILD = 4'd7,
    OP_LAST   = 4'd8,
    OP_PUSH   = 4'd9,
    OP_POP    = 4'd10
  } ptr_op_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_BOUNDS = 2'd1,
    ERR_OVF    = 2'd2,
    ERR_UNF    = 2'd3
  } ptr_err_e;

endpackage

// File: rtl/ptr_stack.sv
// ptr_stack: small parametrised LIFO of W-bit pointers.
//   clk, rst_n  - clock, asynchronous active-low reset (clears contents)
//   push_i      - write data_i on top (ignored when full)
//   pop_i       - drop top entry (ignored when empty); push wins if both
//   data_i      - entry to push
//   top_o       - current top entry (valid when !empty_o)
//   full_o, empty_o, count_o - occupancy
module ptr_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  top_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] top_idx;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign top_idx = count_q - CW'(1);
  assign top_o   = mem_q[top_idx[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !full_o) begin
      mem_q[count_q[AW-1:0]] <= data_i;
      count_q                <= count_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/heap_pointer.sv
// heap_pointer: registered index into an array-backed heap, moved by one
// navigation command per accepted handshake, bounds-checked against
// last_index, with a small saved-pointer stack and a sticky error code.
//   clk, rst        - clock, asynchronous active-low reset
//   cmd_valid/ready - command handshake; a command is taken on a rising edge
//                     where both are high. The block holds cmd_ready low for
//                     the one cycle ptr_valid is high, so accepts are at most
//                     every other cycle. cmd_op/load_value/last_index/err_clr
//                     are sampled on that edge.
//   cmd_op          - ptr_op_e opcode; undefined codes act as NOP
//   load_value      - operand for OP_LOAD
//   last_index      - highest valid heap index
//   err_clr         - clears err_code (a same-cycle new error wins)
//   pointer         - current index
//   ptr_valid       - one-cycle pulse after every accepted command
//   at_root/at_leaf - pointer == 0 / 2*pointer+1 > last_index
//   stk_count       - saved entries
//   err_code        - ptr_err_e, first error held until err_clr
module heap_pointer
  import heap_pkg::*;
#(
  parameter int W           = 32,
  parameter int STACK_DEPTH = 4,
  localparam int CW         = $clog2(STACK_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [W-1:0]  load_value,
  input  logic [W-1:0]  last_index,
  input  logic          err_clr,
  output logic [W-1:0]  pointer,
  output logic          ptr_valid,
  output logic          at_root,
  output logic          at_leaf,
  output logic [CW-1:0] stk_count,
  output logic [1:0]    err_code
);

  // Two guard bits: 2*pointer+2 can reach 2^(W+1), which would wrap
  // back to a small in-range value in only W+1 bits.
  localparam int XW = W + 2;

  logic [W-1:0]  pointer_q, pointer_d;
  logic          ptr_valid_q;
  ptr_err_e      err_q, err_d;

  logic          accept;
  logic [XW-1:0] ptr_x, lim_x, cand;
  logic          check, illegal, want_push, want_pop;
  ptr_err_e      new_err, err_src;
  logic [W-1:0]  stk_top;
  logic          stk_full, stk_empty;

  assign cmd_ready = ~ptr_valid_q;
  assign accept    = cmd_valid & cmd_ready;
  assign ptr_x     = {2'b00, pointer_q};
  assign lim_x     = {2'b00, last_index};

  always_comb begin
    cand      = ptr_x;
    check     = 1'b0;
    illegal   = 1'b0;
    want_push = 1'b0;
    want_pop  = 1'b0;
    new_err   = ERR_NONE;
    case (ptr_op_e'(cmd_op))
      OP_LOAD:   begin cand = {2'b00, load_value}; check = 1'b1; end
      OP_CLR:    cand = '0;
      OP_INC:    begin cand = ptr_x + XW'(1); check = 1'b1; end
      OP_DEC:    begin
                   cand    = ptr_x - XW'(1);
                   check   = 1'b1;
                   illegal = (pointer_q == '0);
                 end
      OP_PARENT: begin
                   cand    = (ptr_x - XW'(1)) >> 1;
                   check   = 1'b1;
                   illegal = (pointer_q == '0);
                 end
      OP_LCHILD: begin cand = (ptr_x << 1) + XW'(1); check = 1'b1; end
      OP_RCHILD: begin cand = (ptr_x << 1) + XW'(2); check = 1'b1; end
      OP_LAST:   cand = lim_x;
      OP_PUSH:   begin
                   if (stk_full) new_err = ERR_OVF;
                   else          want_push = 1'b1;
                 end
      OP_POP:    begin
                   if (stk_empty) new_err = ERR_UNF;
                   else begin
                     want_pop = 1'b1;
                     cand     = {2'b00, stk_top};
                   end
                 end
      default:   ;
    endcase
    if (check && (illegal || (cand > lim_x))) new_err = ERR_BOUNDS;

    pointer_d = pointer_q;
    if (accept && (new_err == ERR_NONE)) pointer_d = cand[W-1:0];

    err_src = accept ? new_err : ERR_NONE;
    // Sticky: only record when empty; a clear reloads with this cycle's error.
    err_d = err_q;
    if (err_clr || (err_q == ERR_NONE)) err_d = err_src;
  end

  ptr_stack #(.W(W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (accept & want_push),
    .pop_i   (accept & want_pop),
    .data_i  (pointer_q),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty),
    .count_o (stk_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pointer_q   <= '0;
      ptr_valid_q <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      pointer_q   <= pointer_d;
      ptr_valid_q <= accept;
      err_q       <= err_d;
    end
  end

  assign pointer   = pointer_q;
  assign ptr_valid = ptr_valid_q;
  assign err_code  = err_q;
  assign at_root   = (pointer_q == '0);
  assign at_leaf   = ({pointer_q, 1'b1} > {1'b0, last_index});

endmodule
